// File: rtl/operand_sum_formatter_if.sv
// Byte handshake between the operand/sum formatter and the UART TX serializer.
// The master offers tx_data with tx_valid; the slave holds tx_busy while it cannot take a byte.
interface operand_sum_formatter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_busy;

    modport master (output tx_data, output tx_valid, input tx_busy);
    modport slave  (input tx_data, input tx_valid, output tx_busy);
endinterface

// File: rtl/operand_sum_formatter.sv
// Debounces the save buttons, latches operands A/B, keeps their sum and streams it as ASCII hex + CR LF.
// Define OPERAND_ECHO_EN to prefix each message with "<A>+<B>=".
module operand_sum_formatter #(
    parameter int DATA_W          = 3,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    save_a_n,
    input  logic                    save_b_n,
    input  logic [DATA_W-1:0]       data_input,
    operand_sum_formatter_if.master tx,
    output logic [DATA_W:0]         sum
);
    localparam int NDIG = (DATA_W + 4) / 4;
    localparam int NW   = NDIG * 4;
`ifdef OPERAND_ECHO_EN
    localparam int BASE = 2 * NDIG + 2;
`else
    localparam int BASE = 0;
`endif
    localparam int MSG_LEN = BASE + NDIG + 2;
    localparam int IW      = $clog2(MSG_LEN);
    localparam int CW      = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

    // Input synchronizers; index 0 is button A, index 1 is button B
    logic [1:0]          btn_s1_q, btn_s2_q;
    logic [DATA_W-1:0]   dat_s1_q, dat_s2_q;
    logic [1:0]          acc_q, acc_d;
    logic [1:0][CW-1:0]  cnt_q, cnt_d;
    logic [1:0]          ev;

    logic [DATA_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [DATA_W:0]     sum_q, sum_d;

    state_t                    state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic                      gap_q, gap_d;
    logic                      pend_q, pend_d;
    logic [MSG_LEN-1:0][7:0]   msg_q, msg_d, msg_new;
    logic [NW-1:0]             sum_x;
`ifdef OPERAND_ECHO_EN
    logic [NW-1:0]             a_x, b_x;
`endif

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    // A level is accepted after DEBOUNCE_CYCLES consecutive differing samples; only 1->0 is an event
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            acc_d[i] = acc_q[i];
            cnt_d[i] = '0;
            ev[i]    = 1'b0;
            if (btn_s2_q[i] != acc_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    acc_d[i] = btn_s2_q[i];
                    ev[i]    = ~btn_s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        op_a_d = ev[0] ? dat_s2_q : op_a_q;
        op_b_d = ev[1] ? dat_s2_q : op_b_q;
        sum_d  = {1'b0, op_a_d} + {1'b0, op_b_d};
    end

    // Byte k of msg_new is the k-th byte on the wire
    always_comb begin
        msg_new = '0;
        sum_x   = NW'(sum_q);
`ifdef OPERAND_ECHO_EN
        a_x = NW'(op_a_q);
        b_x = NW'(op_b_q);
        for (int i = 0; i < NDIG; i++) begin
            msg_new[i]          = hex(a_x[NW-1-4*i -: 4]);
            msg_new[NDIG+1+i]   = hex(b_x[NW-1-4*i -: 4]);
        end
        msg_new[NDIG]       = 8'h2B;
        msg_new[2*NDIG+1]   = 8'h3D;
`endif
        for (int i = 0; i < NDIG; i++)
            msg_new[BASE+i] = hex(sum_x[NW-1-4*i -: 4]);
        msg_new[BASE+NDIG]   = 8'h0D;
        msg_new[BASE+NDIG+1] = 8'h0A;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        pend_d  = pend_q;
        msg_d   = msg_q;
        case (state_q)
            S_IDLE: if ((|ev) || pend_q) state_d = S_LOAD;
            S_LOAD: begin
                msg_d   = msg_new;
                idx_d   = '0;
                pend_d  = 1'b0;
                state_d = S_SEND;
            end
            S_SEND: if (!tx.tx_busy) begin
                gap_d   = 1'b0;
                state_d = S_GAP;
            end
            S_GAP: begin
                // Two quiet cycles give the serializer time to raise busy
                if (!gap_q) begin
                    gap_d = 1'b1;
                end else if (idx_q == IW'(MSG_LEN - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = S_SEND;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if ((|ev) && state_q != S_IDLE) pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1_q <= 2'b11;
            btn_s2_q <= 2'b11;
            dat_s1_q <= '0;
            dat_s2_q <= '0;
            acc_q    <= 2'b11;
            cnt_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            sum_q    <= '0;
            state_q  <= S_IDLE;
            idx_q    <= '0;
            gap_q    <= 1'b0;
            pend_q   <= 1'b0;
            msg_q    <= '0;
        end else begin
            btn_s1_q <= {save_b_n, save_a_n};
            btn_s2_q <= btn_s1_q;
            dat_s1_q <= data_input;
            dat_s2_q <= dat_s1_q;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            sum_q    <= sum_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            pend_q   <= pend_d;
            msg_q    <= msg_d;
        end
    end

    assign tx.tx_valid = (state_q == S_SEND);
    assign tx.tx_data  = msg_q[idx_q];
    assign sum         = sum_q;
endmodule

// File: tb/tb_operand_sum_formatter.sv
// Directed bench for operand_sum_formatter (DATA_W=3, DEBOUNCE_CYCLES=4); honours OPERAND_ECHO_EN.
module tb_operand_sum_formatter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       save_a_n = 1'b1, save_b_n = 1'b1;
    logic [2:0] data_input = 3'd0;
    logic [3:0] sum;

    operand_sum_formatter_if bus();

    operand_sum_formatter #(.DATA_W(3), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .save_a_n(save_a_n), .save_b_n(save_b_n),
        .data_input(data_input), .tx(bus.master), .sum(sum)
    );

    always #5 clk = ~clk;

`ifdef OPERAND_ECHO_EN
    localparam int ML = 7;
`else
    localparam int ML = 3;
`endif

    int n_chk = 0, n_pass = 0, cyc = 0, vld_cnt = 0;
    int rx_base = 0, vld_base = 0;
    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic [7:0] exp_q[$];

    always @(posedge clk) begin
        cyc++;
        if (bus.tx_valid) vld_cnt++;
        if (bus.tx_valid && !bus.tx_busy) begin
            rx_q.push_back(bus.tx_data);
            rx_t.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic press(input bit b, input logic [2:0] d);
        data_input = d;
        if (b) save_b_n = 1'b0; else save_a_n = 1'b0;
        step(10);
        save_a_n = 1'b1;
        save_b_n = 1'b1;
        step(10);
    endtask

    task automatic wait_rx(input string tag, input int n);
        int k = 0;
        while (rx_q.size() < rx_base + n && k < 300) begin
            step(1);
            k++;
        end
        chk(tag, rx_q.size() - rx_base, n);
    endtask

    // Compares received bytes with exp_q; bytes inside one message must be 3 cycles apart
    task automatic chk_msg(input string tag);
        chk({tag, " len"}, rx_q.size() - rx_base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (rx_base + i < rx_q.size()) begin
                chk($sformatf("%s b%0d", tag, i), rx_q[rx_base+i], exp_q[i]);
                if (i % ML != 0)
                    chk($sformatf("%s gap%0d", tag, i), rx_t[rx_base+i] - rx_t[rx_base+i-1], 3);
            end
        end
        rx_base = rx_q.size();
    endtask

    initial begin
        bus.tx_busy = 1'b0;
        step(3);
        chk("rst sum", sum, 4'd0);
        chk("rst valid", bus.tx_valid, 1'b0);
        chk("rst data", bus.tx_data, 8'h00);
        reset = 1'b0;
        step(2);
        chk("idle valid", bus.tx_valid, 1'b0);

        // A = 5
        press(1'b0, 3'd5);
        wait_rx("basicA wait", ML);
        step(12);
`ifdef OPERAND_ECHO_EN
        exp_q = '{8'h35, 8'h2B, 8'h30, 8'h3D, 8'h35, 8'h0D, 8'h0A};
`else
        exp_q = '{8'h35, 8'h0D, 8'h0A};
`endif
        chk_msg("basicA");
        chk("basicA sum", sum, 4'd5);

        // B = 7, sum 12 -> "C"
        press(1'b1, 3'd7);
        wait_rx("max wait", ML);
        step(12);
`ifdef OPERAND_ECHO_EN
        exp_q = '{8'h35, 8'h2B, 8'h37, 8'h3D, 8'h43, 8'h0D, 8'h0A};
`else
        exp_q = '{8'h43, 8'h0D, 8'h0A};
`endif
        chk_msg("max");
        chk("max sum", sum, 4'd12);

        // Short glitch must be rejected
        vld_base = vld_cnt;
        data_input = 3'd2;
        save_a_n = 1'b0;
        step(3);
        save_a_n = 1'b1;
        step(30);
        chk("bounce valid", vld_cnt - vld_base, 0);
        chk("bounce sum", sum, 4'd12);
        chk("bounce rx", rx_q.size() - rx_base, 0);

        // Stall in first byte while B is saved twice; one pending message follows
        bus.tx_busy = 1'b1;
        press(1'b0, 3'd3);
        chk("stall valid", bus.tx_valid, 1'b1);
`ifdef OPERAND_ECHO_EN
        chk("stall data0", bus.tx_data, 8'h33);
`else
        chk("stall data0", bus.tx_data, 8'h41);
`endif
        press(1'b1, 3'd1);
`ifdef OPERAND_ECHO_EN
        chk("stall data1", bus.tx_data, 8'h33);
`else
        chk("stall data1", bus.tx_data, 8'h41);
`endif
        press(1'b1, 3'd2);
`ifdef OPERAND_ECHO_EN
        chk("stall data2", bus.tx_data, 8'h33);
`else
        chk("stall data2", bus.tx_data, 8'h41);
`endif
        chk("stall rx", rx_q.size() - rx_base, 0);
        chk("stall sum", sum, 4'd5);
        bus.tx_busy = 1'b0;
        wait_rx("stall wait", 2 * ML);
        step(15);
`ifdef OPERAND_ECHO_EN
        exp_q = '{8'h33, 8'h2B, 8'h37, 8'h3D, 8'h41, 8'h0D, 8'h0A,
                  8'h33, 8'h2B, 8'h32, 8'h3D, 8'h35, 8'h0D, 8'h0A};
`else
        exp_q = '{8'h41, 8'h0D, 8'h0A, 8'h35, 8'h0D, 8'h0A};
`endif
        chk_msg("stall");

        // Reset while the second byte is offered
        data_input = 3'd1;
        save_a_n = 1'b0;
        step(10);
        save_a_n = 1'b1;
        bus.tx_busy = 1'b1;
        wait_rx("rst wait", 1);
`ifdef OPERAND_ECHO_EN
        chk("rst byte0", rx_q[rx_base], 8'h31);
`else
        chk("rst byte0", rx_q[rx_base], 8'h33);
`endif
        rx_base = rx_q.size();
        step(2);
        chk("pre-rst valid", bus.tx_valid, 1'b1);
        reset = 1'b1;
        step(1);
        chk("midrst valid", bus.tx_valid, 1'b0);
        chk("midrst sum", sum, 4'd0);
        chk("midrst data", bus.tx_data, 8'h00);
        reset = 1'b0;
        bus.tx_busy = 1'b0;
        vld_base = vld_cnt;
        step(30);
        chk("postrst valid", vld_cnt - vld_base, 0);
        chk("postrst rx", rx_q.size() - rx_base, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
